pc_target_table: RTL and testbench

Programmable, parametrised branch-target table. It replaces the fixed, initial-block-loaded target LUT with a writable table. Each entry holds a D-bit target plus a mode bit: absolute target, or PC-relative offset added modulo 2**D. It sits beside the fetch stage. The PC update logic presents a lookup index and the current PC, and receives a registered next-PC target one cycle later. Entries are loaded through a write port driven by the controller or testbench.

---
 rtl/pc_pkg.sv | 18 +
 rtl/pc_target_resolve.sv | 20 ++
 rtl/pc_target_table.sv | 109 ++++++++++
 tb/tb_pc_target_table.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types for the programmable branch-target table and its resolver.
package pc_pkg;

  localparam int unsigned DEFAULT_D = 10;

  typedef logic [DEFAULT_D-1:0] pc_t;

  typedef struct packed {
    logic rel;
    pc_t  value;
  } tt_entry_t;

  typedef enum logic {
    TT_CLEAR,
    TT_IDLE
  } tt_state_e;

endpackage

// File: rtl/pc_target_resolve.sv
// Turns a table entry into a next-PC target: PC-relative entries add modulo 2**D,
// absolute entries pass the stored value through.
module pc_target_resolve
  import pc_pkg::*;
#(
  parameter int unsigned D = DEFAULT_D
) (
  input  logic         rel,
  input  logic [D-1:0] value,
  input  logic [D-1:0] pc,
  output logic [D-1:0] target
);

  // D-bit add drops the carry, so two's-complement offsets wrap naturally.
  always_comb begin
    target = value;
    if (rel) target = pc + value;
  end

endmodule

// File: rtl/pc_target_table.sv
// Writable branch-target table: clears itself after reset, then serves one
// registered lookup per cycle with write-first bypass on a same-index write.
module pc_target_table
  import pc_pkg::*;
#(
  parameter int unsigned D            = DEFAULT_D,
  parameter int unsigned A            = 4,
  parameter int unsigned RESET_TARGET = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [A-1:0] wr_addr,
  input  logic [D-1:0] wr_target,
  input  logic         wr_rel,
  output logic         wr_ready,
  input  logic         lk_en,
  input  logic [A-1:0] lk_addr,
  input  logic [D-1:0] lk_pc,
  output logic         lk_ready,
  output logic [D-1:0] target,
  output logic         target_valid,
  output logic         busy
);

  localparam int unsigned DEPTH = 2**A;

  typedef struct packed {
    logic         rel;
    logic [D-1:0] value;
  } entry_t;

  entry_t       mem [DEPTH];
  tt_state_e    state;
  logic [A-1:0] idx;

  logic         wr_acc;
  logic         lk_acc;
  entry_t       lk_entry;
  logic [D-1:0] resolved;

  always_comb begin
    wr_acc   = wr_en && wr_ready;
    lk_acc   = lk_en && lk_ready;
    lk_entry = mem[lk_addr];
    if (wr_acc && (wr_addr == lk_addr)) begin
      lk_entry.rel   = wr_rel;
      lk_entry.value = wr_target;
    end
  end

  pc_target_resolve #(.D(D)) u_resolve (
    .rel    (lk_entry.rel),
    .value  (lk_entry.value),
    .pc     (lk_pc),
    .target (resolved)
  );

  // Storage has no reset of its own; the clear sweep defines every entry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == TT_CLEAR) begin
        mem[idx].rel   <= 1'b0;
        mem[idx].value <= D'(RESET_TARGET);
      end else if (wr_acc) begin
        mem[wr_addr].rel   <= wr_rel;
        mem[wr_addr].value <= wr_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= TT_CLEAR;
      idx          <= '0;
      target       <= '0;
      target_valid <= 1'b0;
      busy         <= 1'b1;
      wr_ready     <= 1'b0;
      lk_ready     <= 1'b0;
    end else begin
      case (state)
        TT_CLEAR: begin
          target_valid <= 1'b0;
          idx          <= idx + 1'b1;
          if (&idx) begin
            state    <= TT_IDLE;
            busy     <= 1'b0;
            wr_ready <= 1'b1;
            lk_ready <= 1'b1;
          end
        end
        TT_IDLE: begin
          target_valid <= lk_acc;
          if (lk_acc) target <= resolved;
        end
        default: begin
          state        <= TT_CLEAR;
          idx          <= '0;
          target_valid <= 1'b0;
          busy         <= 1'b1;
          wr_ready     <= 1'b0;
          lk_ready     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_target_table.sv
// Scoreboard bench for pc_target_table: expected targets are queued at issue
// and popped whenever target_valid is seen.
module tb_pc_target_table;

  localparam int unsigned D = 10;
  localparam int unsigned A = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         wr_en;
  logic [A-1:0] wr_addr;
  logic [D-1:0] wr_target;
  logic         wr_rel;
  logic         wr_ready;
  logic         lk_en;
  logic [A-1:0] lk_addr;
  logic [D-1:0] lk_pc;
  logic         lk_ready;
  logic [D-1:0] target;
  logic         target_valid;
  logic         busy;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [D-1:0] exp_q [$];

  pc_target_table #(.D(D), .A(A), .RESET_TARGET(0)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_target    (wr_target),
    .wr_rel       (wr_rel),
    .wr_ready     (wr_ready),
    .lk_en        (lk_en),
    .lk_addr      (lk_addr),
    .lk_pc        (lk_pc),
    .lk_ready     (lk_ready),
    .target       (target),
    .target_valid (target_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Results are checked on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (target_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("spurious_valid", 32'(target_valid), 32'd0);
      else chk("target", 32'(target), 32'(exp_q.pop_front()));
    end
  end

  task automatic wr(input logic [A-1:0] a, input logic [D-1:0] v, input logic r);
    wr_en = 1'b1; wr_addr = a; wr_target = v; wr_rel = r;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic lk(input logic [A-1:0] a, input logic [D-1:0] pc, input logic [D-1:0] exp);
    lk_en = 1'b1; lk_addr = a; lk_pc = pc;
    exp_q.push_back(exp);
    cyc();
    lk_en = 1'b0;
  endtask

  // Counts busy cycles after reset release; optional lookups during the sweep must be ignored.
  task automatic sweep_wait(input logic poke);
    int n = 0;
    lk_en = poke; lk_addr = 4'd5; lk_pc = 10'h0;
    while (busy === 1'b1 && n < 100) begin
      cyc();
      n++;
    end
    lk_en = 1'b0;
    chk("sweep_len", 32'(n), 32'd16);
    chk("ready_after_sweep", {30'd0, wr_ready, lk_ready}, 32'd3);
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_target = '0; wr_rel = 1'b0;
    lk_en = 1'b0; lk_addr = '0; lk_pc = '0;
    repeat (2) cyc();
    chk("rst_target", 32'(target), 32'd0);
    chk("rst_valid", 32'(target_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_lk_ready", 32'(lk_ready), 32'd0);
    reset = 1'b0;
    sweep_wait(1'b1);

    lk(4'd5, 10'h0, 10'h000);
    cyc();
    chk("valid_drop", 32'(target_valid), 32'd0);

    wr(4'd1, 10'd11, 1'b0);
    wr(4'd2, 10'd17, 1'b0);
    lk_en = 1'b1;
    lk_addr = 4'd1; exp_q.push_back(10'd11); cyc();
    lk_addr = 4'd2; exp_q.push_back(10'd17); cyc();
    lk_addr = 4'd0; exp_q.push_back(10'd0);  cyc();
    lk_en = 1'b0;
    cyc();

    wr(4'd3, 10'h3FF, 1'b1);
    lk(4'd3, 10'h004, 10'h003);
    wr(4'd4, 10'h3FB, 1'b1);
    lk(4'd4, 10'h001, 10'h3FC);
    wr(4'd6, 10'h014, 1'b1);
    lk(4'd6, 10'h3F0, 10'h004);
    lk_pc = 10'h155;
    cyc();
    chk("target_hold", 32'(target), 32'h004);

    wr_en = 1'b1; wr_addr = 4'd7; wr_target = 10'd100; wr_rel = 1'b0;
    lk(4'd7, 10'h0, 10'd100);
    wr_en = 1'b0;
    wr(4'd9, 10'd55, 1'b0);
    wr_en = 1'b1; wr_addr = 4'd8; wr_target = 10'd77; wr_rel = 1'b0;
    lk(4'd9, 10'h0, 10'd55);
    wr_en = 1'b0;
    lk(4'd8, 10'h0, 10'd77);
    wr_en = 1'b1; wr_addr = 4'd10; wr_target = 10'h010; wr_rel = 1'b1;
    lk(4'd10, 10'h020, 10'h030);
    wr_en = 1'b0;
    cyc();

    lk_en = 1'b1; lk_addr = 4'd1; reset = 1'b1;
    cyc();
    lk_en = 1'b0; reset = 1'b0;
    chk("rst_drop_valid", 32'(target_valid), 32'd0);
    repeat (7) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    sweep_wait(1'b0);

    lk_en = 1'b1; lk_pc = 10'h123;
    for (int i = 0; i < 16; i++) begin
      lk_addr = A'(i);
      exp_q.push_back(10'h000);
      cyc();
    end
    lk_en = 1'b0;
    repeat (3) cyc();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
